// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
//   Fetch sequencer sitting between the PC register, the instruction ROM and
//   the IF/ID stage. Every cycle it computes pc_din, the value the PC register
//   loads on the next rising edge. It also drives the ROM request/ack
//   handshake and presents fetched instructions on if_*. It applies ID stall,
//   branch redirect and, optionally, exception redirect.
//
//   Optional feature: define FETCH_CTRL_EXC_EN to make exc_valid/exc_target
//   live. An exception redirect then has priority over a branch redirect.
//   Without the macro the exc_* ports exist but are ignored.
//
// Parameters
//   RESET_PC    PC value driven on pc_din while fetch_rst is high
//   NOP_INST    reset/flush value of if_inst
//
// Ports
//   fetch_clk   clock, shared with the PC register
//   fetch_rst   synchronous active-high reset
//   pc          current PC register output (fetch address)
//   pc_din      next PC, loaded by the PC register every edge
//   irom_req    fetch request
//   irom_addr   fetch address (= pc)
//   irom_ack    ROM data valid this cycle, completes the request
//   irom_rdata  instruction word, valid with irom_ack
//   id_stall    ID cannot accept; hold if_*
//   br_valid    branch/jump redirect from EX
//   br_target   branch target
//   exc_valid   exception/ertn redirect (FETCH_CTRL_EXC_EN only)
//   exc_target  exception/ertn target
//   if_valid    if_pc/if_inst hold a live instruction
//   if_pc       PC of the presented instruction
//   if_inst     presented instruction
// ---------------------------------------------------------------------------
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h1C00_0000,
  parameter logic [31:0] NOP_INST = 32'h0340_0000
) (
  input  logic        fetch_clk,
  input  logic        fetch_rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_din,
  output logic        irom_req,
  output logic [31:0] irom_addr,
  input  logic        irom_ack,
  input  logic [31:0] irom_rdata,
  input  logic        id_stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_valid,
  input  logic [31:0] exc_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic        if_valid_r, if_valid_s;
  logic [31:0] if_pc_r, if_pc_s;
  logic [31:0] if_inst_r, if_inst_s;
  logic [31:0] buf_pc_r, buf_pc_s;
  logic [31:0] buf_inst_r, buf_inst_s;
  logic [31:0] pend_target_r, pend_target_s;

  logic        redir_s;
  logic [31:0] redir_target_s;
  logic [31:0] pc_inc_s;

`ifdef FETCH_CTRL_EXC_EN
  // Redirect source select: an exception/ertn outranks a branch.
  always_comb begin
    redir_s = exc_valid | br_valid;
    if (exc_valid) begin
      redir_target_s = exc_target;
    end else begin
      redir_target_s = br_target;
    end
  end
`else
  // Redirect source select: only branches redirect in this build.
  always_comb begin
    redir_s        = br_valid;
    redir_target_s = br_target;
  end

  // The exception inputs are present on the port list but have no effect here.
  logic unused_exc_s;
  assign unused_exc_s = exc_valid ^ (^exc_target);
`endif

  // Sequential fetch address; wraps naturally at 2^32.
  assign pc_inc_s  = pc + 32'd4;
  assign irom_addr = pc;

  assign if_valid = if_valid_r;
  assign if_pc    = if_pc_r;
  assign if_inst  = if_inst_r;

  // Next-state, next-PC, ROM request and IF/ID register updates.
  always_comb begin
    state_s       = state_r;
    if_valid_s    = if_valid_r;
    if_pc_s       = if_pc_r;
    if_inst_s     = if_inst_r;
    buf_pc_s      = buf_pc_r;
    buf_inst_s    = buf_inst_r;
    pend_target_s = pend_target_r;
    pc_din        = pc;
    irom_req      = 1'b0;

    // A redirect flushes the IF/ID slot and the hold buffer, even when ID is stalled.
    if (redir_s) begin
      if_valid_s = 1'b0;
      if_inst_s  = NOP_INST;
      buf_pc_s   = 32'd0;
      buf_inst_s = 32'd0;
    end else begin
      if_valid_s = if_valid_r;
    end

    case (state_r)
      ST_BOOT: begin
        state_s = ST_FETCH;
        if (redir_s) begin
          pc_din = redir_target_s;
        end else begin
          pc_din = pc;
        end
      end

      ST_FETCH: begin
        irom_req = 1'b1;
        if (redir_s) begin
          if (irom_ack) begin
            // Returned word belongs to the abandoned path; restart at the target.
            pc_din = redir_target_s;
          end else begin
            // The ROM must still complete at the current address; remember where to go.
            pc_din        = pc;
            pend_target_s = redir_target_s;
            state_s       = ST_DROP;
          end
        end else if (irom_ack) begin
          pc_din = pc_inc_s;
          if (!id_stall) begin
            if_valid_s = 1'b1;
            if_pc_s    = pc;
            if_inst_s  = irom_rdata;
          end else begin
            // ID still owns if_*; park the new word until it frees up.
            buf_pc_s   = pc;
            buf_inst_s = irom_rdata;
            state_s    = ST_HOLD;
          end
        end else begin
          pc_din = pc;
          if (!id_stall) begin
            if_valid_s = 1'b0;
          end else begin
            if_valid_s = if_valid_r;
          end
        end
      end

      ST_HOLD: begin
        if (redir_s) begin
          pc_din  = redir_target_s;
          state_s = ST_FETCH;
        end else if (!id_stall) begin
          pc_din     = pc;
          if_valid_s = 1'b1;
          if_pc_s    = buf_pc_r;
          if_inst_s  = buf_inst_r;
          state_s    = ST_FETCH;
        end else begin
          pc_din  = pc;
          state_s = ST_HOLD;
        end
      end

      ST_DROP: begin
        irom_req = 1'b1;
        // Newest redirect wins while the stale request drains.
        if (redir_s) begin
          pend_target_s = redir_target_s;
        end else begin
          pend_target_s = pend_target_r;
        end
        if (irom_ack) begin
          state_s = ST_FETCH;
          if (redir_s) begin
            pc_din = redir_target_s;
          end else begin
            pc_din = pend_target_r;
          end
        end else begin
          pc_din = pc;
        end
      end

      default: begin
        state_s = ST_BOOT;
        pc_din  = pc;
      end
    endcase

    // Reset overrides everything combinational that leaves the block.
    if (fetch_rst) begin
      pc_din   = RESET_PC;
      irom_req = 1'b0;
    end else begin
      irom_req = irom_req;
    end
  end

  // State and IF/ID registers with synchronous reset.
  always_ff @(posedge fetch_clk) begin
    if (fetch_rst) begin
      state_r       <= ST_BOOT;
      if_valid_r    <= 1'b0;
      if_pc_r       <= 32'd0;
      if_inst_r     <= NOP_INST;
      buf_pc_r      <= 32'd0;
      buf_inst_r    <= 32'd0;
      pend_target_r <= 32'd0;
    end else begin
      state_r       <= state_s;
      if_valid_r    <= if_valid_s;
      if_pc_r       <= if_pc_s;
      if_inst_r     <= if_inst_s;
      buf_pc_r      <= buf_pc_s;
      buf_inst_r    <= buf_inst_s;
      pend_target_r <= pend_target_s;
    end
  end

endmodule
